// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: 24-hour BCD time-of-day counter with a two-button
// mode/set editor and a blink mask for the field being edited.
module clock_set_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       blink_tick,
  input  logic       btn_mode,
  input  logic       btn_up,
  output logic [3:0] h_ten,
  output logic [3:0] h_one,
  output logic [3:0] m_ten,
  output logic [3:0] m_one,
  output logic [3:0] s_ten,
  output logic [3:0] s_one,
  output logic [5:0] blank,
  output logic [1:0] mode,
  output logic       day_pulse
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic       blink_phase;
  logic       phase_nx;
  logic [5:0] blank_nx;
  logic       sec_wrap;
  logic       min_wrap;
  logic       hour_wrap;

  // Two-digit BCD increment; the caller handles the field wrap.
  function automatic logic [7:0] bcd_inc(input logic [3:0] ten, input logic [3:0] one);
    if (one == 4'd9) return {ten + 4'd1, 4'd0};
    else             return {ten, one + 4'd1};
  endfunction

  assign mode      = state;
  assign sec_wrap  = (s_ten == 4'd5) && (s_one == 4'd9);
  assign min_wrap  = (m_ten == 4'd5) && (m_one == 4'd9);
  assign hour_wrap = (h_ten == 4'd2) && (h_one == 4'd3);

  // Next mode and blink phase; mode changes and edits force the phase to 0.
  always_comb begin
    state_nx = state;
    phase_nx = blink_phase;
    if (btn_mode) begin
      state_nx = state_t'(state + 2'd1);
      phase_nx = 1'b0;
    end else if (state == RUN) begin
      phase_nx = 1'b0;
    end else if (btn_up) begin
      phase_nx = 1'b0;
    end else if (blink_tick) begin
      phase_nx = ~blink_phase;
    end
  end

  // Blank mask derived from the next mode/phase so it registers alongside them.
  always_comb begin
    blank_nx = 6'b000000;
    if (phase_nx) begin
      case (state_nx)
        SET_H:   blank_nx = 6'b110000;
        SET_M:   blank_nx = 6'b001100;
        SET_S:   blank_nx = 6'b000011;
        default: blank_nx = 6'b000000;
      endcase
    end
  end

  // Mode FSM, time counting/editing and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      blink_phase <= 1'b0;
      blank       <= 6'b000000;
      day_pulse   <= 1'b0;
      h_ten       <= 4'd0;
      h_one       <= 4'd0;
      m_ten       <= 4'd0;
      m_one       <= 4'd0;
      s_ten       <= 4'd0;
      s_one       <= 4'd0;
    end else begin
      state       <= state_nx;
      blink_phase <= phase_nx;
      blank       <= blank_nx;
      day_pulse   <= 1'b0;
      if (!btn_mode) begin
        case (state)
          RUN: begin
            if (tick_1hz) begin
              if (sec_wrap) begin
                {s_ten, s_one} <= 8'h00;
                if (min_wrap) begin
                  {m_ten, m_one} <= 8'h00;
                  if (hour_wrap) begin
                    {h_ten, h_one} <= 8'h00;
                    day_pulse      <= 1'b1;
                  end else begin
                    {h_ten, h_one} <= bcd_inc(h_ten, h_one);
                  end
                end else begin
                  {m_ten, m_one} <= bcd_inc(m_ten, m_one);
                end
              end else begin
                {s_ten, s_one} <= bcd_inc(s_ten, s_one);
              end
            end
          end
          SET_H: begin
            if (btn_up) begin
              if (hour_wrap) {h_ten, h_one} <= 8'h00;
              else           {h_ten, h_one} <= bcd_inc(h_ten, h_one);
            end
          end
          SET_M: begin
            if (btn_up) begin
              if (min_wrap) {m_ten, m_one} <= 8'h00;
              else          {m_ten, m_one} <= bcd_inc(m_ten, m_one);
            end
          end
          SET_S: begin
            if (btn_up) {s_ten, s_one} <= 8'h00;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed testbench for clock_set_ctrl.
module tb_clock_set_ctrl;

  logic       clk;
  logic       rst;
  logic       tick_1hz;
  logic       blink_tick;
  logic       btn_mode;
  logic       btn_up;
  logic [3:0] h_ten, h_one, m_ten, m_one, s_ten, s_one;
  logic [5:0] blank;
  logic [1:0] mode;
  logic       day_pulse;

  int checkCount = 0;
  int failCount  = 0;

  clock_set_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .blink_tick (blink_tick),
    .btn_mode   (btn_mode),
    .btn_up     (btn_up),
    .h_ten      (h_ten),
    .h_one      (h_one),
    .m_ten      (m_ten),
    .m_one      (m_one),
    .s_ten      (s_ten),
    .s_one      (s_one),
    .blank      (blank),
    .mode       (mode),
    .day_pulse  (day_pulse)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] digits();
    return {8'h00, h_ten, h_one, m_ten, m_one, s_ten, s_one};
  endfunction

  // One comparison: count it and report a mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One-cycle pulse on the selected inputs; returns at the following negedge
  task automatic applyStimulus(input logic t, input logic b, input logic m, input logic u);
    @(negedge clk);
    tick_1hz   = t;
    blink_tick = b;
    btn_mode   = m;
    btn_up     = u;
    @(negedge clk);
    tick_1hz   = 1'b0;
    blink_tick = 1'b0;
    btn_mode   = 1'b0;
    btn_up     = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    tick_1hz   = 1'b0;
    blink_tick = 1'b0;
    btn_mode   = 1'b0;
    btn_up     = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_time", digits(), 32'h000000);
    checkOutput("reset_mode", {30'd0, mode}, 32'd0);
    checkOutput("reset_blank", {26'd0, blank}, 32'd0);
    checkOutput("reset_day", {31'd0, day_pulse}, 32'd0);
    rst = 1'b1;

    // 3725 s = 1 h 2 min 5 s
    repeat (3725) applyStimulus(1, 0, 0, 0);
    checkOutput("run_3725_time", digits(), 32'h010205);
    checkOutput("run_3725_blank", {26'd0, blank}, 32'd0);
    checkOutput("run_3725_mode", {30'd0, mode}, 32'd0);

    // SET_H editing
    applyStimulus(0, 0, 1, 0);
    checkOutput("seth_mode", {30'd0, mode}, 32'd1);
    checkOutput("seth_blank", {26'd0, blank}, 32'd0);
    repeat (21) applyStimulus(0, 0, 0, 1);
    checkOutput("seth_22", digits(), 32'h220205);
    applyStimulus(1, 0, 0, 0);
    checkOutput("seth_tick_frozen", digits(), 32'h220205);
    applyStimulus(0, 0, 0, 1);
    checkOutput("seth_23", digits(), 32'h230205);
    applyStimulus(0, 0, 0, 1);
    checkOutput("seth_wrap_00", digits(), 32'h000205);
    applyStimulus(0, 0, 0, 1);
    checkOutput("seth_01", digits(), 32'h010205);
    repeat (22) applyStimulus(0, 0, 0, 1);
    checkOutput("seth_back_23", digits(), 32'h230205);

    // SET_M blink behaviour
    applyStimulus(0, 0, 1, 0);
    checkOutput("setm_mode", {30'd0, mode}, 32'd2);
    checkOutput("setm_blank0", {26'd0, blank}, 32'd0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("setm_blink1", {26'd0, blank}, 32'b001100);
    applyStimulus(0, 1, 0, 0);
    checkOutput("setm_blink2", {26'd0, blank}, 32'd0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("setm_blink3", {26'd0, blank}, 32'b001100);
    applyStimulus(0, 1, 0, 0);
    checkOutput("setm_blink4", {26'd0, blank}, 32'd0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("setm_blink5", {26'd0, blank}, 32'b001100);
    applyStimulus(0, 0, 0, 1);
    checkOutput("setm_up_unblank", {26'd0, blank}, 32'd0);
    checkOutput("setm_up_min", digits(), 32'h230305);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 1);
    checkOutput("setm_blink_up_same", {26'd0, blank}, 32'd0);
    checkOutput("setm_min_04", digits(), 32'h230405);
    repeat (54) applyStimulus(0, 0, 0, 1);
    checkOutput("setm_min_58", digits(), 32'h235805);

    // SET_S clear and return to RUN with a simultaneous tick
    applyStimulus(0, 0, 1, 0);
    checkOutput("sets_mode", {30'd0, mode}, 32'd3);
    applyStimulus(0, 1, 0, 0);
    checkOutput("sets_blink", {26'd0, blank}, 32'b000011);
    applyStimulus(0, 0, 0, 1);
    checkOutput("sets_clear", digits(), 32'h235800);
    checkOutput("sets_clear_blank", {26'd0, blank}, 32'd0);
    applyStimulus(1, 0, 1, 0);
    checkOutput("sets_to_run_mode", {30'd0, mode}, 32'd0);
    checkOutput("sets_to_run_tick_lost", digits(), 32'h235800);

    // Day rollover
    repeat (118) applyStimulus(1, 0, 0, 0);
    checkOutput("run_235958", digits(), 32'h235958);
    applyStimulus(1, 0, 0, 0);
    checkOutput("run_235959", digits(), 32'h235959);
    checkOutput("run_day_low", {31'd0, day_pulse}, 32'd0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("run_rollover", digits(), 32'h000000);
    checkOutput("run_day_high", {31'd0, day_pulse}, 32'd1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("run_day_one_cycle", {31'd0, day_pulse}, 32'd0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("run_up_ignored", digits(), 32'h000000);
    applyStimulus(0, 1, 0, 0);
    checkOutput("run_blink_ignored", {26'd0, blank}, 32'd0);

    // Mode and up together in SET_H
    repeat (37) applyStimulus(1, 0, 0, 0);
    checkOutput("run_000037", digits(), 32'h000037);
    applyStimulus(1, 0, 1, 0);
    checkOutput("run_to_seth_tick_lost", digits(), 32'h000037);
    repeat (5) applyStimulus(0, 0, 0, 1);
    checkOutput("seth_05", digits(), 32'h050037);
    applyStimulus(0, 0, 1, 1);
    checkOutput("mode_up_mode", {30'd0, mode}, 32'd2);
    checkOutput("mode_up_hours", digits(), 32'h050037);

    // SET_S from 37
    applyStimulus(0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("sets_frozen", digits(), 32'h050037);
    applyStimulus(0, 0, 0, 1);
    checkOutput("sets_37_clear", digits(), 32'h050000);
    applyStimulus(1, 0, 1, 0);
    checkOutput("sets_run_mode2", {30'd0, mode}, 32'd0);
    checkOutput("sets_run_sec00", digits(), 32'h050000);
    applyStimulus(1, 0, 0, 0);
    checkOutput("run_resume_01", digits(), 32'h050001);

    // Asynchronous reset during SET_M
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 1, 0);
    checkOutput("pre_reset_mode", {30'd0, mode}, 32'd2);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_time", digits(), 32'h000000);
    checkOutput("async_reset_mode", {30'd0, mode}, 32'd0);
    checkOutput("async_reset_blank", {26'd0, blank}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1, 0, 0, 0);
    checkOutput("post_reset_tick", digits(), 32'h000001);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
